digit_serial_mult_ctrl: RTL and testbench

DIGIT_SERIAL_MULT_CTRL -- requirements
Module: digit_serial_mult_ctrl

---
 rtl/digit_serial_mult_ctrl.sv | 114 +++++++++++
 tb/tb_digit_serial_mult_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_mult_ctrl.sv
// Digit-serial W x W unsigned multiplier controller that drives an external 2x2 multiplier one digit pair per cycle.
// Latency: N_DIGITS^2 RUN cycles after start, then a 1-cycle done pulse. With EARLY_ZERO_EN a zero operand finishes in 1 cycle.
// Backpressure: none. start_in is only sampled in IDLE, and the operands are latched on that edge.
module digit_serial_mult_ctrl #(
  parameter int N_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_in,
  input  logic [2*N_DIGITS-1:0]   a_in,
  input  logic [2*N_DIGITS-1:0]   b_in,
  output logic [1:0]              mult_a_out,
  output logic [1:0]              mult_b_out,
  input  logic [3:0]              mult_p_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [4*N_DIGITS-1:0]   p_out
);

  localparam int W  = 2 * N_DIGITS;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] LAST = CW'(N_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [PW-1:0]  acc;
  logic [CW-1:0]  i;
  logic [CW-1:0]  j;
  logic [CW:0]    ij_sum;
  logic [PW-1:0]  partial;
  logic           zero_op;
  logic           last_pair;

`ifdef EARLY_ZERO_EN
  assign zero_op = (a_in == '0) || (b_in == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign last_pair = (i == LAST) && (j == LAST);
  assign ij_sum    = {1'b0, i} + {1'b0, j};
  // The digit product is weighted by 4^(i+j). It always fits in the 2W-bit accumulator.
  assign partial   = PW'(mult_p_in) << {ij_sum, 1'b0};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept start only in IDLE, finish on the last digit pair
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in) state_nxt = zero_op ? DONE : RUN;
      RUN:     if (last_pair) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, digit counters (i outer, j inner) and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            a_reg <= a_in;
            b_reg <= b_in;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
          end
        end
        RUN: begin
          acc <= acc + partial;
          if (j == LAST) begin
            j <= '0;
            i <= (i == LAST) ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Digit selection toward the external multiplier; quiet outside RUN
  always_comb begin
    mult_a_out = 2'b00;
    mult_b_out = 2'b00;
    if (state == RUN) begin
      mult_a_out = a_reg[{i, 1'b0} +: 2];
      mult_b_out = b_reg[{j, 1'b0} +: 2];
    end
  end

  assign busy_out = (state != IDLE);
  assign done_out = (state == DONE);
  assign p_out    = acc;

endmodule

// File: tb/tb_digit_serial_mult_ctrl.sv
// Scoreboard bench for digit_serial_mult_ctrl: the driver queues expected results and the negedge monitor checks them.
// Latency: the expected done cycle is derived from the start edge, which is N^2 edges later (or 1 edge for an early-zero operand).
// Backpressure: none. The driver waits for IDLE before issuing each operation (EARLY_ZERO_EN aware).
module tb_digit_serial_mult_ctrl;

  localparam int N  = 4;
  localparam int W  = 2 * N;
  localparam int PW = 2 * W;
`ifdef EARLY_ZERO_EN
  localparam bit EZ = 1'b1;
`else
  localparam bit EZ = 1'b0;
`endif

  typedef struct {
    logic [PW-1:0] p;
    int            t;
    int            lat;
    int            bsy;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_in;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [1:0]    mult_a_out;
  logic [1:0]    mult_b_out;
  logic [3:0]    mult_p_in;
  logic          busy_out;
  logic          done_out;
  logic [PW-1:0] p_out;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  bit   mon_en = 1'b0;
  logic [PW-1:0] hold_p = '0;
  exp_t exp_q[$];

  digit_serial_mult_ctrl #(.N_DIGITS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_in   (start_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .mult_a_out (mult_a_out),
    .mult_b_out (mult_b_out),
    .mult_p_in  (mult_p_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .p_out      (p_out)
  );

  // The external 2x2 multiplier is purely combinational.
  assign mult_p_in = mult_a_out * mult_b_out;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic exp_t make_exp(input logic [W-1:0] a, input logic [W-1:0] b, input int t);
    exp_t e;
    bit   z;
    z     = EZ && (a == '0 || b == '0);
    e.p   = PW'(a) * PW'(b);
    e.t   = t;
    e.lat = z ? 1 : N * N;
    e.bsy = z ? 1 : N * N + 1;
    e.a   = a;
    e.b   = b;
    return e;
  endfunction

  // Monitor: check the done pulse, the digit stream while running, and the quiet outputs while idle.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      int   k;
      if (busy_out) busy_cnt++;
      else          busy_cnt = 0;
      if (done_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("product", p_out, e.p);
          check("latency", cyc - e.t, e.lat);
          check("busy_cycles", busy_cnt, e.bsy);
          hold_p = e.p;
        end
      end else if (busy_out) begin
        if (exp_q.size() == 0) begin
          check("busy_without_op", 1, 0);
        end else begin
          e = exp_q[0];
          k = cyc - e.t;
          if (k < 0 || k >= N * N) begin
            check("run_cycle_range", k, 0);
          end else begin
            check("digit_a", mult_a_out, (int'(e.a) >> (2 * (k / N))) & 3);
            check("digit_b", mult_b_out, (int'(e.b) >> (2 * (k % N))) & 3);
          end
        end
      end else begin
        check("idle_digits", {mult_a_out, mult_b_out}, 0);
        check("idle_hold_p", p_out, hold_p);
      end
      if (rst) hold_p = '0;
    end
  end

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!busy_out) return;
    end
    check("wait_idle_timeout", 1, 0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    a_in = a; b_in = b; start_in = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(make_exp(a, b, cyc));
    @(negedge clk);
    start_in = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int d;
    bit seen;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start_in = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy_out, 0);
    check("reset_done", done_out, 0);
    check("reset_p", p_out, 0);
    check("reset_digits", {mult_a_out, mult_b_out}, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    run_op(8'hFF, 8'hFF);
    run_op(8'h00, 8'h37);
    run_op(8'h37, 8'h00);
    run_op(8'hE4, 8'h1B);

    // Hold start through a whole operation while the inputs change underneath it.
    wait_idle();
    a_in = 8'h12; b_in = 8'h34; start_in = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(make_exp(8'h12, 8'h34, cyc));
    @(negedge clk);
    a_in = 8'h56; b_in = 8'h78;
    seen = 1'b0;
    d = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (done_out) begin seen = 1'b1; d = cyc; end
    end
    check("held_start_done_seen", seen, 1);
    exp_q.push_back(make_exp(8'h56, 8'h78, d + 2));
    @(negedge clk);
    check("held_start_idle_gap", busy_out, 0);
    @(negedge clk);
    start_in = 1'b0;
    check("held_start_restart", busy_out, 1);

    // Reset in RUN cycle 7 aborts the operation.
    wait_idle();
    a_in = 8'hA5; b_in = 8'h3C; start_in = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    exp_q.push_back(make_exp(8'hA5, 8'h3C, t0));
    @(negedge clk);
    start_in = 1'b0;
    while (cyc < t0 + 7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("abort_busy", busy_out, 0);
    check("abort_p", p_out, 0);
    check("abort_done", done_out, 0);
    run_op(8'h03, 8'h05);

    // Reset takes priority over a simultaneous start.
    wait_idle();
    rst = 1'b1; start_in = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_in = 1'b0;
    check("rst_over_start_busy", busy_out, 0);
    check("rst_over_start_p", p_out, 0);

    for (int n = 0; n < 24; n++) begin
      ra = ($urandom_range(7) == 0) ? '0 : W'($urandom);
      rb = ($urandom_range(7) == 0) ? '0 : W'($urandom);
      run_op(ra, rb);
    end

    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain_queue", exp_q.size(), 0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
